// File: rtl/npu_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npu_buf_pkg
//  Description : Shared types and helpers for the multi-channel result
//                buffer: clear FSM state encoding, channel-select width
//                helper and width-generic saturating signed add.
//  Revision    : 1.0 - initial release
// ============================================================================
package npu_buf_pkg;

    // Clear sequencer states, explicit 1-bit encoding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Channel-select width; a single channel still needs a 1-bit select
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed add of sign-extended operands, clamped to a w-bit signed range
    function automatic logic [63:0] sat_add(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int unsigned        w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)      sat_add = hi;
        else if (s < lo) sat_add = lo;
        else             sat_add = s;
    endfunction

    // True when the same add would have been clamped
    function automatic logic sat_hit(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input int unsigned        w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (s > hi) || (s < lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/res_bank.sv
`default_nettype none
// ============================================================================
//  Module      : res_bank
//  Description : One channel of result storage. Two-stage write pipeline
//                (S1 register + old-value fetch with forwarding, S2
//                overwrite/saturating accumulate), clear-port write,
//                sticky saturation flag and a registered write-first read.
//  Revision    : 1.0 - initial release
// ============================================================================
module res_bank
    import npu_buf_pkg::*;
#(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BIT_DEPTH-1:0]  wr_data,
    input  logic                  acc_mode,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [BIT_DEPTH-1:0]  rd_data,
    output logic                  sat_flag
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [BIT_DEPTH-1:0]  r_mem [DEPTH];

    logic                  r_s1_vld;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [BIT_DEPTH-1:0]  r_s1_data;
    logic                  r_s1_acc;
    logic [BIT_DEPTH-1:0]  r_s1_old;

    logic                  w_s2_wr;
    logic [BIT_DEPTH-1:0]  w_s2_sum;
    logic                  w_s2_sat;
    logic [BIT_DEPTH-1:0]  w_s2_result;
    logic [BIT_DEPTH-1:0]  w_old;

    // A flush cycle kills the S2 write so a squashed entry never lands
    assign w_s2_wr     = r_s1_vld && !flush;
    assign w_s2_sum    = BIT_DEPTH'(sat_add(64'(signed'(r_s1_old)),
                                            64'(signed'(r_s1_data)), BIT_DEPTH));
    assign w_s2_sat    = r_s1_acc && sat_hit(64'(signed'(r_s1_old)),
                                             64'(signed'(r_s1_data)), BIT_DEPTH);
    assign w_s2_result = r_s1_acc ? w_s2_sum : r_s1_data;

    // Old value comes from S2 when it targets the same address, else memory
    assign w_old = (w_s2_wr && (r_s1_addr == wr_addr)) ? w_s2_result : r_mem[wr_addr];

    // S1 pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= wr_en && !flush;
        end
        r_s1_addr <= wr_addr;
        r_s1_data <= wr_data;
        r_s1_acc  <= acc_mode;
        r_s1_old  <= w_old;
    end

    // Storage: clear sweep has priority over the S2 write-back
    always_ff @(posedge clk) begin
        if (clr_en) begin
            r_mem[clr_addr] <= '0;
        end else if (w_s2_wr) begin
            r_mem[r_s1_addr] <= w_s2_result;
        end
    end

    // Sticky saturation flag, cleared by reset or a clear sweep start
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sat_flag <= 1'b0;
        end else if (w_s2_wr && w_s2_sat) begin
            sat_flag <= 1'b1;
        end
    end

    // Registered read port, write-first against the S2 write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (w_s2_wr && (r_s1_addr == rd_addr)) ? w_s2_result : r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/res_buffer_mc.sv
`default_nettype none
// ============================================================================
//  Module      : res_buffer_mc
//  Description : Multi-channel convolution result buffer. NUM_CH banks share
//                a write address; supports overwrite or saturating
//                accumulate, a registered read port with channel select and
//                a self-timed clear sweep over all banks.
//  Revision    : 1.0 - initial release
// ============================================================================
module res_buffer_mc
    import npu_buf_pkg::*;
#(
    parameter  int BIT_DEPTH  = 8,
    parameter  int ADDR_WIDTH = 10,
    parameter  int NUM_CH     = 2,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_start,
    output logic                        busy,
    input  logic [NUM_CH-1:0]           wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [NUM_CH*BIT_DEPTH-1:0] wr_data,
    input  logic                        acc_mode,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [CH_W-1:0]             rd_ch,
    output logic [BIT_DEPTH-1:0]        rd_data,
    output logic                        rd_valid,
    output logic [NUM_CH-1:0]           sat_flag
);
    clr_state_t            r_state;
    clr_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_clr_go;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [CH_W-1:0]       r_rd_ch;
    logic [BIT_DEPTH-1:0]  w_bank_rd [NUM_CH];

    assign busy     = (r_state == ST_CLEAR);
    assign w_clr_go = clear_start && (r_state == ST_IDLE);
    // A clear request in the same cycle wins over any write
    assign w_wr_ok  = !busy && !clear_start;
    assign w_rd_ok  = rd_en && !busy;

    // Clear FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Clear FSM next state: one sweep of DEPTH cycles per accepted request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clear_start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (&r_cnt)      w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Sweep address counter, wraps naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst || w_clr_go) r_cnt <= '0;
        else if (busy)       r_cnt <= r_cnt + 1'b1;
    end

    // Read valid and remembered channel select for the output mux
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            r_rd_ch  <= '0;
        end else begin
            rd_valid <= w_rd_ok;
            if (w_rd_ok) r_rd_ch <= rd_ch;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
        res_bank #(
            .BIT_DEPTH  (BIT_DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .flush    (w_clr_go),
            .clr_en   (busy),
            .clr_addr (r_cnt),
            .wr_en    (wr_en[c] && w_wr_ok),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data[c*BIT_DEPTH +: BIT_DEPTH]),
            .acc_mode (acc_mode),
            .rd_en    (w_rd_ok),
            .rd_addr  (rd_addr),
            .rd_data  (w_bank_rd[c]),
            .sat_flag (sat_flag[c])
        );
    end

    // Output mux; holds because bank read registers only move on a read
    always_comb begin
        rd_data = w_bank_rd[0];
        for (int c = 1; c < NUM_CH; c++) begin
            if (r_rd_ch == CH_W'(c)) rd_data = w_bank_rd[c];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_res_buffer_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_res_buffer_mc
//  Description : Directed testbench for res_buffer_mc with a read-data
//                scoreboard (expected values queued at issue, popped by a
//                monitor when rd_valid is seen).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_res_buffer_mc;
    localparam int BD = 8;
    localparam int AW = 4;
    localparam int NC = 2;

    logic          clk;
    logic          rst;
    logic          clear_start;
    logic          busy;
    logic [NC-1:0] wr_en;
    logic [AW-1:0] wr_addr;
    logic [NC*BD-1:0] wr_data;
    logic          acc_mode;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [0:0]    rd_ch;
    logic [BD-1:0] rd_data;
    logic          rd_valid;
    logic [NC-1:0] sat_flag;

    int checks = 0;
    int errors = 0;
    logic [BD-1:0] exp_q [$];

    res_buffer_mc #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
        .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .acc_mode(acc_mode),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_ch(rd_ch), .rd_data(rd_data),
        .rd_valid(rd_valid), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Monitor: every valid read must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid: got rd_data=%02h, required no valid", rd_data);
            end else begin
                logic [BD-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %02h required %02h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] m, input logic [3:0] a,
                      input logic [7:0] d0, input logic [7:0] d1, input logic acc);
        wr_en    = m;
        wr_addr  = a;
        wr_data  = {d1, d0};
        acc_mode = acc;
        tick();
        wr_en    = 2'b00;
        acc_mode = 1'b0;
    endtask

    task automatic rd(input logic ch, input logic [3:0] a, input logic [7:0] e);
        rd_en   = 1'b1;
        rd_ch   = ch;
        rd_addr = a;
        exp_q.push_back(e);
        tick();
        rd_en   = 1'b0;
    endtask

    // Start a sweep and count busy cycles; optionally poke it while busy
    task automatic clear_sweep(input bit inject);
        int n;
        clear_start = 1'b1;
        if (inject) begin
            wr_en   = 2'b11;
            wr_addr = 4'd4;
            wr_data = 16'h5555;
        end
        tick();
        clear_start = 1'b0;
        wr_en       = 2'b00;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (inject && n == 0) begin
                wr_en   = 2'b01;
                wr_addr = 4'd0;
                wr_data = 16'h0066;
                rd_en   = 1'b1;
                rd_ch   = 1'b0;
                rd_addr = 4'd0;
            end
            if (inject && n == 1) begin
                wr_en = 2'b00;
                rd_en = 1'b0;
                chk("rd_ignored_while_busy", 32'(rd_valid), 32'd0);
            end
            if (inject && n == 2) clear_start = 1'b1;
            if (inject && n == 3) clear_start = 1'b0;
            n++;
            tick();
        end
        chk("busy_cycles", 32'(n), 32'd16);
    endtask

    initial begin
        rst = 1'b1; clear_start = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        acc_mode = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_ch = '0;
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_sat_flag", 32'(sat_flag), 32'd0);
        rst = 1'b0;
        tick();

        // Clear then read back zero
        clear_sweep(1'b0);
        rd(1'b1, 4'd5, 8'h00);

        // Overwrite both channels, read at T+1 and later
        wr(2'b11, 4'd3, 8'h12, 8'h34, 1'b0);
        rd(1'b0, 4'd3, 8'h12);
        rd(1'b1, 4'd3, 8'h34);
        wr(2'b10, 4'd15, 8'h00, 8'hA5, 1'b0);
        rd(1'b1, 4'd15, 8'hA5);

        // Back-to-back accumulates through forwarding: 5+6+7 = 0x12
        clear_sweep(1'b0);
        wr(2'b01, 4'd7, 8'd5, 8'd0, 1'b1);
        wr(2'b01, 4'd7, 8'd6, 8'd0, 1'b1);
        wr(2'b01, 4'd7, 8'd7, 8'd0, 1'b1);
        rd(1'b0, 4'd7, 8'h12);
        chk("sat_after_small_acc", 32'(sat_flag), 32'd0);

        // Positive and negative saturation, sticky flags
        wr(2'b01, 4'd1, 8'd100, 8'd0, 1'b0);
        wr(2'b01, 4'd1, 8'd50, 8'd0, 1'b1);
        rd(1'b0, 4'd1, 8'h7F);
        chk("sat_flag_ch0", 32'(sat_flag), 32'h1);
        wr(2'b10, 4'd2, 8'd0, 8'h9C, 1'b0);
        wr(2'b10, 4'd2, 8'd0, 8'hCE, 1'b1);
        rd(1'b1, 4'd2, 8'h80);
        chk("sat_flag_both", 32'(sat_flag), 32'h3);
        wr(2'b01, 4'd8, 8'd120, 8'd0, 1'b0);
        rd(1'b0, 4'd8, 8'd120);
        chk("sat_overwrite_keeps", 32'(sat_flag), 32'h3);
        clear_sweep(1'b0);
        chk("sat_cleared", 32'(sat_flag), 32'd0);

        // Clear beats write, writes/reads/re-clear while busy are dropped
        clear_sweep(1'b1);
        rd(1'b0, 4'd4, 8'h00);
        rd(1'b1, 4'd4, 8'h00);
        rd(1'b0, 4'd0, 8'h00);

        // Reset in the middle of a sweep
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (5) tick();
        chk("busy_mid_clear", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_mid_sat_flag", 32'(sat_flag), 32'd0);
        clear_sweep(1'b0);
        wr(2'b01, 4'd9, 8'h3C, 8'h00, 1'b0);
        rd(1'b0, 4'd9, 8'h3C);

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/res_buffer_mc.md
Name: res_buffer_mc

Overview:
Multi-channel convolution result buffer. It is the parametrised successor to the fixed two-instance result buffers that sit behind convolve. It stores NUM_CH parallel result streams (sum1, sum2, ...) at a shared write address, with a full 2**ADDR_WIDTH depth per channel. Beyond plain storage, it supports accumulate mode (saturating read-modify-write for multi-input-channel summation), a registered read port, and a self-timed clear sweep.

Parameters:
BIT_DEPTH, 8, width of one stored result (signed two's complement)
ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH entries per channel
NUM_CH, 2, number of parallel channels/banks (>=1)

Ports:
clk  in  1  single clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
clear_start  in  1  pulse: start zeroing sweep of all banks
busy  out  1  high while clear sweep runs
wr_en  in  NUM_CH  per-channel write strobe
wr_addr  in  ADDR_WIDTH  write address shared by all channels
wr_data  in  NUM_CH*BIT_DEPTH  packed data, channel 0 in LSBs
acc_mode  in  1  0 = overwrite, 1 = saturating accumulate into stored value
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_ch  in  CH_W  read channel select, CH_W = max(1, clog2(NUM_CH))
rd_data  out  BIT_DEPTH  read result, registered
rd_valid  out  1  rd_data valid this cycle
sat_flag  out  NUM_CH  sticky per-channel saturation indicator

Behaviour:
- Reset:
  - busy=0, rd_valid=0, rd_data=0, sat_flag=0.
  - Pipeline valids cleared; FSM in IDLE.
  - Memory contents are not reset; use clear_start to zero them.
- Write pipeline, 2 stages. Write sampled in cycle T:
  - S1 (edge end of T) registers mask, addr, data, mode, and old = mem[ch][addr].
  - If S2 writes the same ch/addr in cycle T, old takes the S2 result (forwarding). Back-to-back accumulates to one address are therefore exact.
  - S2 (cycle T+1): result = acc_mode ? sat_add(old, data) : data. It is written at the edge ending T+1.
- Saturation: signed add clamped to [-2^(BIT_DEPTH-1), 2^(BIT_DEPTH-1)-1].
  - On clamp, sat_flag[ch] is set and stays set until rst or clear_start.
  - Overwrite never sets the flag.
- Read:
  - rd_en sampled in cycle R gives rd_data/rd_valid at cycle R+1 (1-cycle latency).
  - rd_valid is high for exactly one cycle per accepted rd_en.
  - Write-first: if S2 writes the same rd_ch/rd_addr in cycle R, the new value is returned.
  - Pending S1 data is not visible. A write sampled at T is readable by a read issued at T+1 or later.
  - rd_data holds its last value when rd_valid=0.
- Clear FSM:
  - IDLE, clear_start: go to CLEAR, busy=1 from the next cycle, counter=0.
  - CLEAR: write 0 to counter address in all banks; counter++.
  - CLEAR, counter==DEPTH-1: write, then return to IDLE. busy is high for exactly DEPTH cycles.
- Boundary rules:
  - clear_start while busy: ignored.
  - clear_start and wr_en in the same cycle: clear wins, write dropped.
  - clear_start squashes in-flight S1/S2 writes; they never reach memory.
  - wr_en while busy: dropped.
  - rd_en while busy: ignored, rd_valid stays 0.
  - rst mid-clear: FSM to IDLE, busy=0 next cycle; banks are partially cleared (contents undefined to verification).
  - Address wrap: counter and addresses are modulo DEPTH, no overflow state.
  - wr_en with all bits 0 is a no-op.

Decomposition:
- Package npu_buf_pkg: sat_add function (parametrised by width), CH_W computation helper, FSM state enum (IDLE, CLEAR).
- Sub-module res_bank: one channel's storage, containing
  - synchronous write,
  - S1 old-value read with forwarding,
  - S2 saturating update with sat output,
  - registered read port.
- Top level instantiates NUM_CH res_banks in a generate loop. It holds the clear FSM, the squash logic and the rd_ch output mux.

Test Plan:
Bench settings: BIT_DEPTH=8, ADDR_WIDTH=4, NUM_CH=2.
1. Clear and read: pulse clear_start -> busy high exactly 16 cycles; afterwards read ch1 addr 5 -> rd_valid at next cycle, rd_data=0x00.
2. Overwrite: at T write ch0 addr3=0x12, ch1 addr3=0x34 (wr_en=2'b11); read ch0 addr3 at T+1 -> 0x12 at T+2; read ch1 -> 0x34.
3. Accumulate forwarding: after clear, acc_mode=1, ch0 addr7 data 5, 6, 7 on consecutive cycles -> read addr7 ch0 = 0x12; sat_flag=0.
4. Saturation:
   - overwrite 100 then acc 50 at ch0 addr1 -> 0x7F, sat_flag[0]=1;
   - overwrite -100 then acc -50 at ch1 addr2 -> 0x80, sat_flag[1]=1;
   - clear_start -> sat_flag=0.
5. Priority and drops:
   - clear_start with wr_en (addr4=0x55) -> after clear, addr4 reads 0;
   - wr_en during busy -> dropped;
   - rd_en during busy -> rd_valid stays 0.
6. Reset mid-clear: rst at clear cycle 6 -> next cycle busy=0, rd_valid=0, sat_flag=0; new clear_start accepted.
